// File: rtl/dram_burst_port.sv
// DRAM-side responder for the cache 8-word burst port.
// Buffers one line and splits it into single-word downstream transactions.
module dram_burst_port (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iDR_Stb,
  input  logic        iDR_Wr,
  input  logic [23:0] iDR_Adr,
  input  logic [31:0] iDR_Data,
  input  logic [3:0]  iDR_Mask,
  input  logic [1:0]  iDR_Load,
  output logic [31:0] oDR_Data,
  output logic        oDR_Ack,
  output logic        oDR_Busy,
  output logic        oMem_Req,
  output logic        oMem_Wr,
  output logic [23:0] oMem_Adr,
  output logic [31:0] oMem_Data,
  output logic [3:0]  oMem_BE,
  input  logic [31:0] iMem_Data,
  input  logic        iMem_Ack
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WFILL = 3'd1;
  localparam logic [2:0] S_WMEM  = 3'd2;
  localparam logic [2:0] S_RMEM  = 3'd3;
  localparam logic [2:0] S_RSTRM = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_wbuf [8];
  logic [31:0] r_rbuf [8];
  logic [2:0]  r_lp;
  logic [3:0]  r_fill;
  logic [2:0]  r_mi;
  logic [2:0]  r_k;
  logic [20:0] r_la;
  logic [3:0]  r_lm;

  logic        w_ld_ok;
  logic        w_ld_rst;
  logic [2:0]  w_ld_idx;
  logic [3:0]  w_fill_nx;
  logic [2:0]  w_mi_nx;
  logic [2:0]  w_k_nx;
  logic [31:0] w_wbuf0;
  logic        w_unused;

  assign w_unused = ^iDR_Adr[2:0];

  assign w_ld_ok  = ((r_state == S_IDLE) || (r_state == S_WFILL))
                    && iDR_Load[0];
  assign w_ld_rst = iDR_Load[1];
  assign w_ld_idx = w_ld_rst ? 3'd0 : r_lp;
  assign w_mi_nx  = r_mi + 3'd1;
  assign w_k_nx   = r_k + 3'd1;

  always_comb begin
    w_fill_nx = r_fill;
    if (w_ld_ok) begin
      if (w_ld_rst)
        w_fill_nx = 4'd1;
      else if (r_fill != 4'd8)
        w_fill_nx = r_fill + 4'd1;
    end
  end

  // word 0 may be written in the same cycle WMEM is entered
  assign w_wbuf0 = (w_ld_ok && (w_ld_idx == 3'd0)) ? iDR_Data
                                                   : r_wbuf[0];

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      for (int i = 0; i < 8; i++) begin
        r_wbuf[i] <= '0;
        r_rbuf[i] <= '0;
      end
    end else begin
      if (w_ld_ok)
        r_wbuf[w_ld_idx] <= iDR_Data;
      if ((r_state == S_RMEM) && iMem_Ack)
        r_rbuf[r_mi] <= iMem_Data;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state   <= S_IDLE;
      r_lp      <= '0;
      r_fill    <= '0;
      r_mi      <= '0;
      r_k       <= '0;
      r_la      <= '0;
      r_lm      <= '0;
      oDR_Data  <= '0;
      oDR_Ack   <= 1'b0;
      oDR_Busy  <= 1'b0;
      oMem_Req  <= 1'b0;
      oMem_Wr   <= 1'b0;
      oMem_Adr  <= '0;
      oMem_Data <= '0;
      oMem_BE   <= '0;
    end else begin
      if (w_ld_ok)
        r_lp <= w_ld_rst ? 3'd1 : r_lp + 3'd1;
      r_fill <= w_fill_nx;
      unique case (r_state)
        S_IDLE: begin
          if (iDR_Stb) begin
            r_la     <= iDR_Adr[23:3];
            r_mi     <= '0;
            oDR_Busy <= 1'b1;
            if (iDR_Wr) begin
              r_lm    <= iDR_Mask;
              r_state <= S_WFILL;
            end else begin
              r_state  <= S_RMEM;
              oMem_Req <= 1'b1;
              oMem_Wr  <= 1'b0;
              oMem_BE  <= 4'hF;
              oMem_Adr <= {iDR_Adr[23:3], 3'd0};
            end
          end
        end
        S_WFILL: begin
          if (w_fill_nx == 4'd8) begin
            r_state   <= S_WMEM;
            r_fill    <= '0;
            r_mi      <= '0;
            oMem_Req  <= 1'b1;
            oMem_Wr   <= 1'b1;
            oMem_Adr  <= {r_la, 3'd0};
            oMem_Data <= w_wbuf0;
            oMem_BE   <= r_lm;
          end
        end
        S_WMEM: begin
          if (iMem_Ack) begin
            r_mi <= w_mi_nx;
            if (r_mi == 3'd7) begin
              r_state   <= S_IDLE;
              oDR_Busy  <= 1'b0;
              oMem_Req  <= 1'b0;
              oMem_Wr   <= 1'b0;
              oMem_Adr  <= '0;
              oMem_Data <= '0;
              oMem_BE   <= '0;
            end else begin
              oMem_Adr  <= {r_la, w_mi_nx};
              oMem_Data <= r_wbuf[w_mi_nx];
            end
          end
        end
        S_RMEM: begin
          if (iMem_Ack) begin
            r_mi <= w_mi_nx;
            if (r_mi == 3'd7) begin
              r_state  <= S_RSTRM;
              r_k      <= '0;
              oMem_Req <= 1'b0;
              oMem_Adr <= '0;
              oMem_BE  <= '0;
              oDR_Data <= r_rbuf[0];
              oDR_Ack  <= 1'b1;
            end else begin
              oMem_Adr <= {r_la, w_mi_nx};
            end
          end
        end
        S_RSTRM: begin
          oDR_Ack <= 1'b0;
          if (r_k == 3'd7) begin
            r_state  <= S_IDLE;
            oDR_Busy <= 1'b0;
            oDR_Data <= '0;
          end else begin
            r_k      <= w_k_nx;
            oDR_Data <= r_rbuf[w_k_nx];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dram_burst_port.md
# dram_burst_port

DRAM-side responder for the cache controller's 8-word burst port (the `DR` interface). It accepts read and write line bursts from the cache controller and buffers one 8×32 line. It converts each burst into eight single-word transactions on a downstream word-memory port. Read data is returned to the cache as one Ack-marked, gap-free 8-cycle stream.

## Interface
- No parameters. Line size is fixed at 8 words of 32 bits; addresses are 24-bit word addresses.
- iClk  in  1  system clock; all logic is rising-edge.
- iRst  in  1  reset, asynchronous assert, active-low (0 = reset).
- iDR_Stb  in  1  burst request strobe; single cycle.
- iDR_Wr  in  1  direction, sampled with iDR_Stb: 1 = line write, 0 = line read.
- iDR_Adr  in  24  line word address; bits [2:0] are ignored and treated as 0.
- iDR_Data  in  32  write word, qualified by iDR_Load.
- iDR_Mask  in  4  byte enables, sampled with iDR_Stb and applied to all 8 write words.
- iDR_Load  in  2  write-buffer load:
  - 2'b11 = store word at index 0 and set load pointer to 1.
  - 2'b01 = store at the load pointer, then increment it.
  - 2'b00 and 2'b10 = no load.
- oDR_Data  out  32  read stream word.
- oDR_Ack  out  1  one-cycle pulse marking read word 0.
- oDR_Busy  out  1  responder not idle; a new iDR_Stb must not be issued while high.
- oMem_Req  out  1  downstream word request, held until acknowledged.
- oMem_Wr  out  1  downstream direction.
- oMem_Adr  out  24  downstream word address.
- oMem_Data  out  32  downstream write word.
- oMem_BE  out  4  downstream byte enables.
- iMem_Data  in  32  downstream read word, valid when iMem_Ack is high.
- iMem_Ack  in  1  downstream completion. It may be high in the same cycle as oMem_Req (zero wait states).

## Operation
- All outputs are registered. Reset value of every output is 0.
- Storage:
  - write buffer wbuf[0..7] and read buffer rbuf[0..7];
  - 3-bit load pointer lp and a 4-bit fill count;
  - 3-bit memory index mi; latched line address la[23:3] and mask lm.
- States:
  - IDLE: oDR_Busy=0.
    - iDR_Stb & iDR_Wr: latch la and lm, go to WFILL.
    - iDR_Stb & ~iDR_Wr: latch la, set mi=0, go to RMEM.
  - WFILL: wait until 8 words have been stored, then set mi=0 and go to WMEM.
  - WMEM: oMem_Req=1, oMem_Wr=1, oMem_Adr={la,mi}, oMem_Data=wbuf[mi], oMem_BE=lm.
    - On iMem_Ack: mi++.
    - After the ack with mi=7: drop oMem_Req and go to IDLE.
  - RMEM: oMem_Req=1, oMem_Wr=0, oMem_BE=4'b1111, oMem_Adr={la,mi}.
    - On iMem_Ack: rbuf[mi]=iMem_Data, mi++.
    - After the ack with mi=7: go to RSTRM with k=0.
  - RSTRM: oDR_Data=rbuf[k] with k=0..7 on consecutive cycles; oDR_Ack=1 only for k=0.
    - After k=7: go to IDLE.
- Write buffer loads (IDLE and WFILL only; ignored in WMEM, RMEM and RSTRM):
  - Load 11 may coincide with iDR_Stb and is accepted in that same cycle.
  - Load 11 during WFILL restarts the fill: pointer goes to 1 and fill count to 1.
  - Load 01 at lp=7 wraps lp to 0; the fill count saturates at 8.
- oDR_Busy=1 in WFILL, WMEM, RMEM and RSTRM. It is registered: it rises the cycle after the accepted iDR_Stb.
- iDR_Stb while not in IDLE is ignored and has no effect.
- Reset at any point returns to IDLE. It drops oMem_Req and oDR_Ack immediately and discards buffered data. Pointers and counters are cleared.
- Downstream address and data must hold stable while oMem_Req=1 and iMem_Ack=0.

## Timing
- Write, with Stb and Load 11 at cycle T, Load 01 at T+1..T+7, and iMem_Ack always high:
  - WFILL from T+1;
  - WMEM from T+8, with oMem_Req high T+8..T+15;
  - oDR_Busy high T+1..T+15.
- Read, with Stb at cycle T and iMem_Ack always high:
  - oMem_Req high T+1..T+8;
  - oDR_Ack and word 0 at T+9;
  - words 1..7 at T+10..T+16;
  - oDR_Busy high T+1..T+16.
- Each downstream wait cycle delays all later events by one cycle.
- The read stream itself never has gaps.

## Test plan
- Reset: hold iRst=0 while driving iDR_Stb=1 -> all outputs stay 0; after release, oDR_Busy=0.
- Write line at Adr 24'h000128 with data 0x100+k and mask 4'hF, zero-wait memory -> eight writes to 24'h000128..24'h00012F, each with oMem_Data=0x100+k and BE=F; oDR_Busy falls at T+16.
- Read line at Adr 24'h00004D (low bits ignored), memory returns 0xA0+index with 2 wait cycles per word -> reads at 24'h000048..24'h00004F; single oDR_Ack with 0xA0, then 0xA1..0xA7 on consecutive cycles.
- Back-to-back write then read (the read Stb sent the first cycle oDR_Busy=0), with a second Stb injected while busy -> the injected Stb is ignored; the read returns the just-written data.
- Load 11 re-issued after 3 words during WFILL -> the fill restarts; WMEM starts only after 8 words counted from the restart.
- Reset asserted in the middle of RSTRM at k=3 -> oDR_Ack=0, oDR_Data=0, state IDLE; a following read completes normally.
